// File: rtl/rally_ctrl_pkg.sv
// Shared constants and state encoding for the PikaBall rally sequencer.
package rally_ctrl_pkg;

    localparam int unsigned VBUF_H           = 240;
    localparam int unsigned DEF_NET_POS      = 160;
    localparam int unsigned DEF_GROUND_Y     = VBUF_H - 20;
    localparam int unsigned DEF_BALL_D       = 24;
    localparam int unsigned DEF_SERVE_TICKS  = 60;
    localparam int unsigned DEF_POINT_TICKS  = 90;
    localparam int unsigned DEF_SCORE_WIN    = 15;
    localparam int unsigned DEF_SCORE_W      = 4;

    // Ball positions are 12 bits; comparisons are widened by one bit so the
    // sprite offset can never wrap.
    localparam int unsigned POS_W = 12;
    localparam int unsigned CMP_W = POS_W + 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } rally_state_e;

endpackage

// File: rtl/rally_ctrl_frame_delay.sv
// Frame-tick driven down-counter used to hold the SERVE and POINT phases.
module rally_ctrl_frame_delay #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    // The hold ends on the tick that arrives once the count has run down.
    assign done = tick && (count_q == '0);

    // Next count: load has priority, otherwise decrement per tick and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rally_ctrl.sv
// PikaBall game-flow sequencer: round FSM, landing detection and score keeping.
module rally_ctrl #(
    parameter int unsigned NET_POS     = rally_ctrl_pkg::DEF_NET_POS,
    parameter int unsigned GROUND_Y    = rally_ctrl_pkg::DEF_GROUND_Y,
    parameter int unsigned BALL_D      = rally_ctrl_pkg::DEF_BALL_D,
    parameter int unsigned SERVE_TICKS = rally_ctrl_pkg::DEF_SERVE_TICKS,
    parameter int unsigned POINT_TICKS = rally_ctrl_pkg::DEF_POINT_TICKS,
    parameter int unsigned SCORE_WIN   = rally_ctrl_pkg::DEF_SCORE_WIN,
    parameter int unsigned SCORE_W     = rally_ctrl_pkg::DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic [11:0]        ball_pos_x,
    input  logic [11:0]        ball_pos_y,
    output logic               ent_rst_n,
    output logic               run_en,
    output logic               serve_side,
    output logic [SCORE_W-1:0] score_p,
    output logic [SCORE_W-1:0] score_n,
    output logic [2:0]         state,
    output logic               winner
);

    import rally_ctrl_pkg::*;

    localparam int unsigned TIMER_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    rally_state_e       state_q, state_d;
    logic               ent_rst_n_q, ent_rst_n_d;
    logic               run_en_q, run_en_d;
    logic               serve_side_q, serve_side_d;
    logic               winner_q, winner_d;
    logic [SCORE_W-1:0] score_p_q, score_p_d;
    logic [SCORE_W-1:0] score_n_q, score_n_d;
    logic               start_q;
    logic               start_rise;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_done;
    logic [CMP_W-1:0]   ball_bottom;
    logic [CMP_W-1:0]   ball_centre;
    logic               landed;
    logic               left_court;
    logic [SCORE_W-1:0] scorer_score;

    assign start_rise  = start_btn && !start_q;
    assign ball_bottom = {1'b0, ball_pos_y} + CMP_W'(BALL_D);
    assign ball_centre = {1'b0, ball_pos_x} + CMP_W'(BALL_D / 2);
    assign landed      = frame_tick && (ball_bottom >= CMP_W'(GROUND_Y));
    assign left_court  = ball_centre < CMP_W'(NET_POS);
    // serve_side already names whoever just scored while in POINT.
    assign scorer_score = serve_side_q ? score_n_q : score_p_q;

    rally_ctrl_frame_delay #(
        .WIDTH (TIMER_W)
    ) u_frame_delay (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .load     (timer_load),
        .load_val (timer_load_val),
        .done     (timer_done)
    );

    // Next-state, score and registered-output decode.
    always_comb begin
        state_d        = state_q;
        serve_side_d   = serve_side_q;
        winner_d       = winner_q;
        score_p_d      = score_p_q;
        score_n_d      = score_n_q;
        timer_load     = 1'b0;
        timer_load_val = TIMER_W'(SERVE_TICKS - 1);

        case (state_q)
            StIdle: begin
                if (start_rise) begin
                    score_p_d    = '0;
                    score_n_d    = '0;
                    serve_side_d = 1'b0;
                    timer_load   = 1'b1;
                    state_d      = StServe;
                end
            end
            StServe: begin
                if (timer_done) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (landed) begin
                    // Ball on the player's half scores for the npc, and vice versa.
                    if (left_court) begin
                        if (score_n_q != SCORE_W'(SCORE_WIN)) begin
                            score_n_d = score_n_q + SCORE_W'(1);
                        end
                        serve_side_d = 1'b1;
                    end else begin
                        if (score_p_q != SCORE_W'(SCORE_WIN)) begin
                            score_p_d = score_p_q + SCORE_W'(1);
                        end
                        serve_side_d = 1'b0;
                    end
                    timer_load     = 1'b1;
                    timer_load_val = TIMER_W'(POINT_TICKS - 1);
                    state_d        = StPoint;
                end
            end
            StPoint: begin
                if (timer_done) begin
                    if (scorer_score == SCORE_W'(SCORE_WIN)) begin
                        winner_d = serve_side_q;
                        state_d  = StOver;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = StServe;
                    end
                end
            end
            StOver: begin
                if (start_rise) begin
                    score_p_d    = '0;
                    score_n_d    = '0;
                    serve_side_d = 1'b0;
                    timer_load   = 1'b1;
                    state_d      = StServe;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ent_rst_n_d = (state_d == StPlay) || (state_d == StPoint) || (state_d == StOver);
        run_en_d    = (state_d == StPlay);
    end

    // State, score and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ent_rst_n_q  <= 1'b0;
            run_en_q     <= 1'b0;
            serve_side_q <= 1'b0;
            winner_q     <= 1'b0;
            score_p_q    <= '0;
            score_n_q    <= '0;
        end else begin
            state_q      <= state_d;
            ent_rst_n_q  <= ent_rst_n_d;
            run_en_q     <= run_en_d;
            serve_side_q <= serve_side_d;
            winner_q     <= winner_d;
            score_p_q    <= score_p_d;
            score_n_q    <= score_n_d;
        end
    end

    // Button history keeps sampling through reset so a held button cannot
    // restart the game when reset is released.
    always_ff @(posedge clk) begin
        start_q <= start_btn;
    end

    assign state      = state_q;
    assign ent_rst_n  = ent_rst_n_q;
    assign run_en     = run_en_q;
    assign serve_side = serve_side_q;
    assign score_p    = score_p_q;
    assign score_n    = score_n_q;
    assign winner     = winner_q;

endmodule
